hsid_x_obi_pixel_fetch: RTL and testbench

OBI read master that streams hyperspectral pixel data from memory into the HSID datapath. It sits directly upstream of the OBI memory slave. Software-style start with base address and word count drives it. It issues sequential word reads and buffers the responses in a small FIFO. Each 32-bit word is serialised into two DATA_WIDTH pixels on a valid/ready stream toward the HSID core.

---
 rtl/hsid_x_obi_inf_pkg.sv | 18 +
 rtl/hsid_x_obi_pixel_fetch.sv | 175 +++++++++++++++++
 tb/tb_hsid_x_obi_pixel_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsid_x_obi_inf_pkg.sv
// rtl/hsid_x_obi_inf_pkg.sv - OBI request/response bundle types shared by HSID OBI blocks
package hsid_x_obi_inf_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_pixel_fetch.sv
// rtl/hsid_x_obi_pixel_fetch.sv - OBI read master fetching words and serialising them into pixels
module hsid_x_obi_pixel_fetch
    import hsid_x_obi_inf_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    output obi_req_t              obi_req,
    input  obi_resp_t             obi_rsp,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_last
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNTF_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WORD_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  req_cnt;
    logic [CNT_WIDTH-1:0]  pop_cnt;
    logic [CNTF_W-1:0]     outstanding;
    logic [CNTF_W-1:0]     fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  half_q;
    logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] head;

    logic credit_ok;
    logic req;
    logic grant;
    logic push;
    logic hs;
    logic pop;
    logic last_word;
    logic start_ok;

    // Words in flight plus words buffered never exceed the FIFO, so a response always has a slot.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNTF_W+1)'(FIFO_DEPTH);
    assign req       = (state_q == FETCH) && credit_ok;
    assign grant     = req && obi_rsp.gnt;
    assign push      = obi_rsp.rvalid && (outstanding != '0);
    assign start_ok  = start && (state_q == IDLE);

    assign head        = fifo_mem[rd_ptr];
    assign pixel_valid = (fifo_count != '0);
    assign hs          = pixel_valid && pixel_ready;
    assign pop         = hs && half_q;
    assign last_word   = (pop_cnt == num_q - CNT_WIDTH'(1));
    assign pixel_last  = pixel_valid && half_q && last_word;

    always_comb begin
        pixel_data = '0;
        if (pixel_valid) begin
            pixel_data = half_q ? head[WORD_WIDTH-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        obi_req       = '0;
        obi_req.req   = req;
        obi_req.addr  = addr_q;
        obi_req.we    = 1'b0;
        obi_req.be    = '1;
        obi_req.wdata = '0;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (grant && (req_cnt == num_q - CNT_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_word) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            num_q       <= '0;
            req_cnt     <= '0;
            pop_cnt     <= '0;
            half_q      <= 1'b0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                addr_q  <= {base_addr[WORD_WIDTH-1:2], 2'b00};
                num_q   <= num_words;
                req_cnt <= '0;
                pop_cnt <= '0;
                half_q  <= 1'b0;
            end else begin
                if (grant) begin
                    addr_q  <= addr_q + WORD_WIDTH'(4);
                    req_cnt <= req_cnt + CNT_WIDTH'(1);
                end
                if (hs) begin
                    half_q <= ~half_q;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + CNT_WIDTH'(1);
                end
            end

            case ({grant, push})
                2'b10:   outstanding <= outstanding + CNTF_W'(1);
                2'b01:   outstanding <= outstanding - CNTF_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNTF_W'(1);
                2'b01:   fifo_count <= fifo_count - CNTF_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: fifo_count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= obi_rsp.rdata[WORD_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_hsid_x_obi_pixel_fetch.sv
// tb/tb_hsid_x_obi_pixel_fetch.sv - directed vector bench for hsid_x_obi_pixel_fetch
`timescale 1ns/1ps
module tb_hsid_x_obi_pixel_fetch;
    import hsid_x_obi_inf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    obi_req_t    obi_req;
    obi_resp_t   obi_rsp;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [15:0] pixel_data;
    logic        pixel_last;

    hsid_x_obi_pixel_fetch #(
        .WORD_WIDTH(32),
        .DATA_WIDTH(16),
        .CNT_WIDTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .obi_req    (obi_req),
        .obi_rsp    (obi_rsp),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_data (pixel_data),
        .pixel_last (pixel_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        int          nw;
        bit          gnt_rand;
        bit          ready_rand;
        int          stall;
        bit          restart;
        int          exp_grants;
        int          exp_pixels;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs[8];

    int passed = 0;
    int total  = 0;

    int          cyc = 0;
    logic [31:0] pend_q[$];
    int          grants, pops, pix_idx, done_cnt, done_cyc, last_hs_cyc, start_cyc, req_seen;
    bit          gnt_rand, ready_rand, ready_hold;
    logic [31:0] cur_base;
    int          cur_nw;
    bit          prev_req_wait, prev_pix_wait, prev_done;
    logic [31:0] prev_addr;
    logic [15:0] prev_pdata;
    logic        prev_plast;
    logic [31:0] first_word;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[13:0], 2'b00, a[29:16]};
    endfunction

    // Memory and downstream sink: drive at negedge+1, sample at negedge+2.
    initial begin
        logic [31:0] ew;
        logic [15:0] ep;
        obi_rsp     = '0;
        pixel_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend_q.delete();
                obi_rsp       = '0;
                pixel_ready   = 1'b0;
                prev_req_wait = 0;
                prev_pix_wait = 0;
                prev_done     = 0;
            end else begin
                obi_rsp.gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    obi_rsp.rvalid = 1'b1;
                    obi_rsp.rdata  = mem_word(pend_q[0]);
                end else begin
                    obi_rsp.rvalid = 1'b0;
                    obi_rsp.rdata  = '0;
                end
                pixel_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            end
            #1;
            cyc++;
            if (!rst) begin
                if (start && !busy) start_cyc = cyc;
                if (prev_req_wait) chk(obi_req.req && obi_req.addr == prev_addr, "req_hold", obi_req.addr, prev_addr);
                if (obi_req.req) begin
                    req_seen++;
                    chk((grants - pops) < 4, "credit", 32'(grants - pops), 32'd3);
                end
                if (obi_req.req && obi_rsp.gnt) begin
                    chk(obi_req.addr == cur_base + 32'(4 * grants), "addr", obi_req.addr, cur_base + 32'(4 * grants));
                    pend_q.push_back(obi_req.addr);
                    grants++;
                end
                prev_req_wait = obi_req.req && !obi_rsp.gnt;
                prev_addr     = obi_req.addr;
                if (obi_rsp.rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
                if (prev_pix_wait)
                    chk(pixel_valid && pixel_data == prev_pdata && pixel_last == prev_plast,
                        "pix_hold", {pixel_last, pixel_data}, {prev_plast, prev_pdata});
                if (pixel_valid && pixel_ready) begin
                    ew = mem_word(cur_base + 32'(4 * (pix_idx / 2)));
                    ep = (pix_idx % 2 == 1) ? ew[31:16] : ew[15:0];
                    chk(pixel_data == ep, "pixel_data", pixel_data, ep);
                    chk(pixel_last == (pix_idx == 2 * cur_nw - 1), "pixel_last", pixel_last, 32'(pix_idx == 2 * cur_nw - 1));
                    if (pix_idx == 0) first_word[15:0] = pixel_data;
                    if (pix_idx == 1) first_word[31:16] = pixel_data;
                    if (pix_idx % 2 == 1) pops++;
                    pix_idx++;
                    last_hs_cyc = cyc;
                end
                prev_pix_wait = pixel_valid && !pixel_ready;
                prev_pdata    = pixel_data;
                prev_plast    = pixel_last;
                if (prev_done) chk(!busy, "busy_after_done", busy, 0);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = done;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(obi_req.req == 0 && obi_req.addr == 0 && obi_req.we == 0 && obi_req.be == 4'hF && obi_req.wdata == 0,
            {tag, "_obi_req"}, {obi_req.req, obi_req.be, obi_req.addr[26:0]}, {1'b0, 4'hF, 27'd0});
        chk(!busy && !done, {tag, "_busy_done"}, {busy, done}, 0);
        chk(!pixel_valid && !pixel_last && pixel_data == 0, {tag, "_pixel"}, {pixel_valid, pixel_last, pixel_data}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit finished = 0;
        cur_base    = v.base & 32'hFFFF_FFFC;
        cur_nw      = v.nw;
        grants      = 0;
        pops        = 0;
        pix_idx     = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        last_hs_cyc = -1;
        start_cyc   = -1;
        req_seen    = 0;
        first_word  = '0;
        gnt_rand    = v.gnt_rand;
        ready_rand  = v.ready_rand;
        ready_hold  = (v.stall > 0);
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        num_words = 16'(v.nw);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start     = v.restart && (k == 4);
            base_addr = v.restart ? 32'h0000_2000 : 32'hDEAD_0000;
            num_words = 16'd3;
            #3;
            if (v.stall > 0 && k == v.stall) begin
                chk(grants == 4, "stall_grants", grants, 4);
                chk(!obi_req.req, "stall_req_low", obi_req.req, 0);
                ready_hold = 0;
            end
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
        end
        chk(finished, "timeout", finished, 1);
        @(negedge clk);
        #3;
        chk(grants == v.exp_grants, "grant_count", grants, v.exp_grants);
        chk(pix_idx == v.exp_pixels, "pixel_count", pix_idx, v.exp_pixels);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        if (v.nw == 0) begin
            chk(done_cyc == start_cyc + 1, "done_latency_empty", done_cyc - start_cyc, 1);
            chk(req_seen == 0, "no_req_empty", req_seen, 0);
        end else begin
            chk(done_cyc == last_hs_cyc + 1, "done_latency", done_cyc - last_hs_cyc, 1);
            chk(first_word == v.exp_first, "first_word", first_word, v.exp_first);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000,  2, 0, 0,  0, 0,  2,  4, 32'h1000_0000};
        vecs[1] = '{32'h0000_1000,  0, 0, 0,  0, 0,  0,  0, 32'h0000_0000};
        vecs[2] = '{32'h0001_2340, 16, 1, 0,  0, 0, 16, 32, 32'h2340_0001};
        vecs[3] = '{32'h0002_0100,  8, 0, 0, 20, 0,  8, 16, 32'h0100_0002};
        vecs[4] = '{32'h0000_3FF3,  5, 1, 1,  0, 0,  5, 10, 32'h3FF0_0000};
        vecs[5] = '{32'hFFFF_FFF8,  4, 0, 0,  0, 0,  4,  8, 32'h3FF8_3FFF};
        vecs[6] = '{32'h0000_0500,  6, 1, 1,  0, 1,  6, 12, 32'h0500_0000};
        vecs[7] = '{32'h0000_0700,  3, 1, 0,  0, 0,  3,  6, 32'h0700_0000};

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        gnt_rand   = 0;
        ready_rand = 0;
        ready_hold = 0;
        cur_base   = '0;
        cur_nw     = 0;
        grants     = 0;
        pops       = 0;
        pix_idx    = 0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort in DRAIN: all requests granted, pixels held back downstream.
        cur_base   = 32'h0000_0600;
        cur_nw     = 4;
        grants     = 0;
        pops       = 0;
        pix_idx    = 0;
        gnt_rand   = 0;
        ready_rand = 0;
        ready_hold = 1;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h0000_0600;
        num_words = 16'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && grants < 4; k++) @(negedge clk);
        chk(grants == 4, "drain_grants", grants, 4);
        @(negedge clk);
        @(negedge clk);
        #3;
        chk(busy && !obi_req.req, "in_drain", {busy, obi_req.req}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check_reset_outputs("abort");
        @(negedge clk);
        rst        = 1'b0;
        ready_hold = 0;
        run_vec(vecs[7]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
